// File: rtl/trace_pkg.sv
// Shared types and field layout for the execution-trace streamer.
// A record is four 32-bit words: HDR, PC, INSTR, ALU.
package trace_pkg;

  localparam int WORDS_PER_RECORD = 4;
  localparam int WORD_W           = 32;
  localparam int REC_W            = WORDS_PER_RECORD * WORD_W;
  localparam int SEQ_W            = 24;
  localparam int DROP_CNT_W       = 16;

  localparam int HDR_DROP_BIT = 31;
  localparam int HDR_REGW_BIT = 30;
  localparam int HDR_MEMW_BIT = 29;
  localparam int HDR_MEMR_BIT = 28;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PC,
    ST_INSTR,
    ST_ALU
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] hdr;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] alu;
  } trace_rec_t;

  function automatic logic [WORD_W-1:0] make_hdr(
    input logic             drop,
    input logic             reg_write,
    input logic             mem_write,
    input logic             mem_read,
    input logic [SEQ_W-1:0] seq
  );
    logic [WORD_W-1:0] h;
    h               = '0;
    h[SEQ_W-1:0]    = seq;
    h[HDR_DROP_BIT] = drop;
    h[HDR_REGW_BIT] = reg_write;
    h[HDR_MEMW_BIT] = mem_write;
    h[HDR_MEMR_BIT] = mem_read;
    return h;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO with first-word-fall-through read; a push is accepted while
// full when a pop happens in the same cycle.
module trace_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count
  // alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/exec_trace_streamer.sv
// Captures retired-instruction records into a FIFO and streams each one as
// four words over a valid/ready interface, counting records lost to overflow.
module exec_trace_streamer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    iCapture,
  input  logic [31:0]             iPC,
  input  logic [31:0]             iInstruction,
  input  logic [31:0]             iAluResult,
  input  logic                    iRegWrite,
  input  logic                    iMemWrite,
  input  logic                    iMemRead,
  input  logic                    iClearOverflow,
  output logic [31:0]             oData,
  output logic                    oValid,
  input  logic                    iReady,
  output logic                    oLast,
  output logic [$clog2(DEPTH):0]  oCount,
  output logic [DROP_CNT_W-1:0]   oDropCount,
  output logic                    oOverflow
);

  state_t                state_q, state_d;
  trace_rec_t            hold_q, hold_d;
  logic [SEQ_W-1:0]      seq_q, seq_d;
  logic                  pend_q, pend_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  ovf_q, ovf_d;

  trace_rec_t wrec;
  trace_rec_t fifo_rdata;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic       drop;

  // A record leaves the FIFO when the streamer is idle or finishing a record.
  assign fifo_pop  = !fifo_empty && ((state_q == ST_IDLE) || (state_q == ST_ALU && iReady));
  assign fifo_push = iCapture && (!fifo_full || fifo_pop);
  assign drop      = iCapture && fifo_full && !fifo_pop;

  always_comb begin
    wrec.hdr   = make_hdr(pend_q, iRegWrite, iMemWrite, iMemRead, seq_q);
    wrec.pc    = iPC;
    wrec.instr = iInstruction;
    wrec.alu   = iAluResult;
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (wrec),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (oCount)
  );

  // NOTE: every variable gets its default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    seq_d      = seq_q;
    pend_d     = pend_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_HDR;
      ST_HDR:   if (iReady) state_d = ST_PC;
      ST_PC:    if (iReady) state_d = ST_INSTR;
      ST_INSTR: if (iReady) state_d = ST_ALU;
      ST_ALU:   if (iReady) state_d = fifo_empty ? ST_IDLE : ST_HDR;
      default:  state_d = ST_IDLE;
    endcase

    if (fifo_pop) hold_d = fifo_rdata;
    if (iCapture) seq_d = seq_q + 1'b1;

    if (fifo_push)  pend_d = 1'b0;
    else if (drop)  pend_d = 1'b1;

    // A drop wins over a coincident clear so the loss is never hidden.
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end else if (iClearOverflow) begin
      ovf_d = 1'b0;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      seq_q      <= '0;
      pend_q     <= 1'b0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      pend_q     <= pend_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Holding register contents are only observed outside IDLE.
  always_ff @(posedge clock) begin
    hold_q <= hold_d;
  end

  always_comb begin
    oValid = (state_q != ST_IDLE);
    oLast  = (state_q == ST_ALU);
    unique case (state_q)
      ST_HDR:   oData = hold_q.hdr;
      ST_PC:    oData = hold_q.pc;
      ST_INSTR: oData = hold_q.instr;
      ST_ALU:   oData = hold_q.alu;
      default:  oData = '0;
    endcase
  end

  assign oDropCount = drop_cnt_q;
  assign oOverflow  = ovf_q;

endmodule

// File: tb/tb_exec_trace_streamer.sv
// Self-checking bench for exec_trace_streamer: directed scenarios with fixed
// expectations plus a randomized run against a queue-based reference model.
module tb_exec_trace_streamer;

  localparam int DEPTH = 16;

  logic        clock;
  logic        reset_n;
  logic        iCapture;
  logic [31:0] iPC, iInstruction, iAluResult;
  logic        iRegWrite, iMemWrite, iMemRead;
  logic        iClearOverflow;
  logic [31:0] oData;
  logic        oValid;
  logic        iReady;
  logic        oLast;
  logic [4:0]  oCount;
  logic [15:0] oDropCount;
  logic        oOverflow;

  int n_checks = 0;
  int n_errors = 0;

  exec_trace_streamer #(.DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .iCapture       (iCapture),
    .iPC            (iPC),
    .iInstruction   (iInstruction),
    .iAluResult     (iAluResult),
    .iRegWrite      (iRegWrite),
    .iMemWrite      (iMemWrite),
    .iMemRead       (iMemRead),
    .iClearOverflow (iClearOverflow),
    .oData          (oData),
    .oValid         (oValid),
    .iReady         (iReady),
    .oLast          (oLast),
    .oCount         (oCount),
    .oDropCount     (oDropCount),
    .oOverflow      (oOverflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] hdr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu;
  } mrec_t;

  mrec_t       m_q[$];
  mrec_t       m_cur;
  bit          m_busy = 0;
  int          m_idx  = 0;
  int unsigned m_seq  = 0;
  bit          m_pend = 0;
  int          m_drops = 0;
  bit          m_ovf  = 0;

  function automatic logic [31:0] m_word(input mrec_t r, input int i);
    case (i)
      0: return r.hdr;
      1: return r.pc;
      2: return r.instr;
      default: return r.alu;
    endcase
  endfunction

  // Applies one clock edge's worth of spec rules to the model.
  task automatic model_edge();
    bit    hs, pop, full, dropped;
    mrec_t nr;
    logic [23:0] s;
    if (!reset_n) begin
      m_q.delete();
      m_busy = 0; m_idx = 0; m_seq = 0; m_pend = 0; m_drops = 0; m_ovf = 0;
      return;
    end
    hs      = m_busy && iReady;
    full    = (m_q.size() == DEPTH);
    pop     = (m_q.size() > 0) && (!m_busy || (hs && m_idx == 3));
    dropped = 0;
    if (pop) begin
      m_cur = m_q.pop_front(); m_busy = 1; m_idx = 0;
    end else if (hs) begin
      if (m_idx == 3) begin m_busy = 0; m_idx = 0; end
      else m_idx = m_idx + 1;
    end
    if (iCapture) begin
      if (!full || pop) begin
        s = m_seq[23:0];
        nr.hdr   = {m_pend, iRegWrite, iMemWrite, iMemRead, 4'h0, s};
        nr.pc    = iPC;
        nr.instr = iInstruction;
        nr.alu   = iAluResult;
        m_q.push_back(nr);
        m_pend = 0;
      end else begin
        dropped = 1;
        m_pend  = 1;
        m_ovf   = 1;
        if (m_drops < 65535) m_drops = m_drops + 1;
      end
      m_seq = (m_seq + 1) % (1 << 24);
    end
    if (iClearOverflow && !dropped) m_ovf = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic set_cap(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] alu,
                         input logic rw, input logic mw, input logic mr);
    iCapture = 1'b1; iPC = pc; iInstruction = ins; iAluResult = alu;
    iRegWrite = rw; iMemWrite = mw; iMemRead = mr;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; iCapture = 1'b0; iClearOverflow = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    set_cap(32'hDEAD0000, 32'h1, 32'h2, 1'b1, 1'b1, 1'b1);
    iReady = 1'b0;
    tick(); tick();
    n_checks++; if (oValid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", oValid); end
    n_checks++; if (oData !== 32'h0) begin n_errors++; $display("FAIL reset_data: got %h expected 0", oData); end
    n_checks++; if (oLast !== 1'b0) begin n_errors++; $display("FAIL reset_last: got %b expected 0", oLast); end
    n_checks++; if (oCount !== 5'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", oCount); end
    n_checks++; if (oDropCount !== 16'd0) begin n_errors++; $display("FAIL reset_dropcount: got %0d expected 0", oDropCount); end
    n_checks++; if (oOverflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %b expected 0", oOverflow); end
    iCapture = 1'b0;
    reset_n  = 1'b1;
    tick();
    n_checks++; if (oValid !== 1'b0) begin n_errors++; $display("FAIL reset_capture_ignored: valid got %b expected 0", oValid); end
    n_checks++; if (oCount !== 5'd0) begin n_errors++; $display("FAIL reset_capture_ignored_count: got %0d expected 0", oCount); end
  endtask

  task automatic test_single_record();
    logic [31:0] exp_w [4];
    exp_w = '{32'h40000000, 32'h00000010, 32'h00500093, 32'h00000005};
    iReady = 1'b1;
    set_cap(32'h00000010, 32'h00500093, 32'h00000005, 1'b1, 1'b0, 1'b0);
    tick();
    iCapture = 1'b0;
    tick();
    for (int w = 0; w < 4; w++) begin
      n_checks++; if (oValid !== 1'b1) begin n_errors++; $display("FAIL single_valid w%0d: got %b expected 1", w, oValid); end
      n_checks++; if (oData !== exp_w[w]) begin n_errors++; $display("FAIL single_data w%0d: got %h expected %h", w, oData, exp_w[w]); end
      n_checks++; if (oLast !== (w == 3)) begin n_errors++; $display("FAIL single_last w%0d: got %b expected %b", w, oLast, (w == 3)); end
      tick();
    end
    n_checks++; if (oValid !== 1'b0) begin n_errors++; $display("FAIL single_idle_after: valid got %b expected 0", oValid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] pc, ins, alu;
    pc = $urandom; ins = $urandom; alu = $urandom;
    iReady = 1'b1;
    set_cap(pc, ins, alu, 1'b0, 1'b1, 1'b0);
    tick();
    iCapture = 1'b0;
    tick();
    n_checks++; if (oData !== 32'h20000001) begin n_errors++; $display("FAIL bp_hdr: got %h expected %h", oData, 32'h20000001); end
    tick();
    n_checks++; if (oData !== pc) begin n_errors++; $display("FAIL bp_pc: got %h expected %h", oData, pc); end
    iReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (oValid !== 1'b1) begin n_errors++; $display("FAIL bp_hold_valid c%0d: got %b expected 1", i, oValid); end
      n_checks++; if (oData !== pc) begin n_errors++; $display("FAIL bp_hold_data c%0d: got %h expected %h", i, oData, pc); end
    end
    iReady = 1'b1;
    tick();
    n_checks++; if (oData !== ins) begin n_errors++; $display("FAIL bp_instr: got %h expected %h", oData, ins); end
    tick();
    n_checks++; if (oData !== alu || oLast !== 1'b1) begin n_errors++; $display("FAIL bp_alu: got %h last %b expected %h last 1", oData, oLast, alu); end
    tick();
    n_checks++; if (oValid !== 1'b0) begin n_errors++; $display("FAIL bp_idle: valid got %b expected 0", oValid); end
  endtask

  task automatic test_overflow();
    logic [31:0] st_pc [18];
    logic [31:0] st_in [18];
    logic [31:0] st_al [18];
    logic        st_rw [18];
    logic [31:0] exp;
    int rec, w;
    apply_reset();
    iReady = 1'b0;
    for (int k = 0; k < 18; k++) begin
      st_pc[k] = $urandom; st_in[k] = $urandom; st_al[k] = $urandom; st_rw[k] = k[0];
      set_cap(st_pc[k], st_in[k], st_al[k], st_rw[k], 1'b0, 1'b0);
      tick();
    end
    iCapture = 1'b0;
    n_checks++; if (oDropCount !== 16'd1) begin n_errors++; $display("FAIL ovf_dropcount: got %0d expected 1", oDropCount); end
    n_checks++; if (oOverflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b expected 1", oOverflow); end
    n_checks++; if (oCount !== 5'd16) begin n_errors++; $display("FAIL ovf_count: got %0d expected 16", oCount); end
    iReady = 1'b1;
    rec = 0; w = 0;
    for (int c = 0; c < 200 && rec < 17; c++) begin
      if (oValid) begin
        case (w)
          0: exp = (st_rw[rec] ? 32'h40000000 : 32'h0) | rec;
          1: exp = st_pc[rec];
          2: exp = st_in[rec];
          default: exp = st_al[rec];
        endcase
        n_checks++; if (oData !== exp || oLast !== (w == 3)) begin n_errors++; $display("FAIL ovf_stream r%0d w%0d: got %h last %b expected %h last %b", rec, w, oData, oLast, exp, (w == 3)); end
        if (w == 3) begin rec++; w = 0; end else w++;
      end
      tick();
    end
    n_checks++; if (rec !== 17) begin n_errors++; $display("FAIL ovf_records_streamed: got %0d expected 17", rec); end
    n_checks++; if (oValid !== 1'b0 || oCount !== 5'd0) begin n_errors++; $display("FAIL ovf_drained: valid %b count %0d expected 0 0", oValid, oCount); end
    set_cap($urandom, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    tick();
    iCapture = 1'b0;
    tick();
    n_checks++; if (oValid !== 1'b1 || oData !== 32'h80000012) begin n_errors++; $display("FAIL ovf_drop_hdr: valid %b data %h expected 1 %h", oValid, oData, 32'h80000012); end
    repeat (4) tick();
    set_cap($urandom, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    tick();
    iCapture = 1'b0;
    tick();
    n_checks++; if (oData !== 32'h00000013) begin n_errors++; $display("FAIL ovf_pending_cleared: got %h expected %h", oData, 32'h00000013); end
    repeat (4) tick();
  endtask

  task automatic test_full_pop();
    apply_reset();
    iReady = 1'b0;
    for (int k = 0; k < 17; k++) begin
      set_cap($urandom, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
      tick();
    end
    iCapture = 1'b0;
    n_checks++; if (oCount !== 5'd16 || oDropCount !== 16'd0) begin n_errors++; $display("FAIL fullpop_fill: count %0d drops %0d expected 16 0", oCount, oDropCount); end
    iReady = 1'b1;
    repeat (3) tick();
    n_checks++; if (oLast !== 1'b1) begin n_errors++; $display("FAIL fullpop_at_alu: last got %b expected 1", oLast); end
    set_cap($urandom, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    tick();
    iCapture = 1'b0;
    n_checks++; if (oDropCount !== 16'd0 || oOverflow !== 1'b0) begin n_errors++; $display("FAIL fullpop_no_drop: drops %0d ovf %b expected 0 0", oDropCount, oOverflow); end
    n_checks++; if (oCount !== 5'd16) begin n_errors++; $display("FAIL fullpop_count: got %0d expected 16", oCount); end
    n_checks++; if (oData !== 32'h00000001) begin n_errors++; $display("FAIL fullpop_next_hdr: got %h expected %h", oData, 32'h00000001); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ins0;
    apply_reset();
    iReady = 1'b0;
    for (int k = 0; k < 18; k++) begin
      logic [31:0] ins;
      ins = $urandom;
      if (k == 0) ins0 = ins;
      set_cap($urandom, ins, $urandom, 1'b0, 1'b0, 1'b0);
      tick();
    end
    iCapture = 1'b0;
    n_checks++; if (oDropCount !== 16'd1) begin n_errors++; $display("FAIL rstmid_pre_drops: got %0d expected 1", oDropCount); end
    iReady = 1'b1;
    tick(); tick();
    n_checks++; if (oData !== ins0) begin n_errors++; $display("FAIL rstmid_instr: got %h expected %h", oData, ins0); end
    reset_n = 1'b0;
    tick();
    n_checks++; if (oValid !== 1'b0 || oLast !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid: valid %b last %b expected 0 0", oValid, oLast); end
    n_checks++; if (oCount !== 5'd0 || oDropCount !== 16'd0 || oOverflow !== 1'b0) begin n_errors++; $display("FAIL rstmid_counters: count %0d drops %0d ovf %b expected 0 0 0", oCount, oDropCount, oOverflow); end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (oValid !== 1'b0) begin n_errors++; $display("FAIL rstmid_no_partial c%0d: valid got %b expected 0", i, oValid); end
    end
    set_cap($urandom, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
    tick();
    iCapture = 1'b0;
    tick();
    n_checks++; if (oValid !== 1'b1 || oData !== 32'h40000000) begin n_errors++; $display("FAIL rstmid_seq0: valid %b data %h expected 1 %h", oValid, oData, 32'h40000000); end
    repeat (4) tick();
  endtask

  task automatic test_clear_overflow();
    apply_reset();
    iReady = 1'b0;
    for (int k = 0; k < 17; k++) begin
      set_cap($urandom, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
      tick();
    end
    set_cap($urandom, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    iClearOverflow = 1'b1;
    tick();
    iCapture = 1'b0; iClearOverflow = 1'b0;
    n_checks++; if (oOverflow !== 1'b1 || oDropCount !== 16'd1) begin n_errors++; $display("FAIL clr_coincide: ovf %b drops %0d expected 1 1", oOverflow, oDropCount); end
    tick();
    n_checks++; if (oOverflow !== 1'b1) begin n_errors++; $display("FAIL clr_sticky: got %b expected 1", oOverflow); end
    iClearOverflow = 1'b1;
    tick();
    iClearOverflow = 1'b0;
    n_checks++; if (oOverflow !== 1'b0 || oDropCount !== 16'd1) begin n_errors++; $display("FAIL clr_alone: ovf %b drops %0d expected 0 1", oOverflow, oDropCount); end
  endtask

  task automatic test_random();
    logic [31:0] exp_d;
    int ready_pct;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      ready_pct = ((c / 500) % 2 == 0) ? 30 : 85;
      reset_n        = ($urandom_range(0, 199) != 0);
      iCapture       = ($urandom_range(0, 99) < 55);
      iPC            = $urandom;
      iInstruction   = $urandom;
      iAluResult     = $urandom;
      iRegWrite      = $urandom_range(0, 1);
      iMemWrite      = $urandom_range(0, 1);
      iMemRead       = $urandom_range(0, 1);
      iClearOverflow = ($urandom_range(0, 99) < 3);
      iReady         = ($urandom_range(0, 99) < ready_pct);
      tick();
      n_checks++; if (oValid !== m_busy) begin n_errors++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, oValid, m_busy); end
      if (m_busy) begin
        exp_d = m_word(m_cur, m_idx);
        n_checks++; if (oData !== exp_d) begin n_errors++; $display("FAIL rnd_data c%0d: got %h expected %h", c, oData, exp_d); end
      end
      n_checks++; if (oLast !== (m_busy && m_idx == 3)) begin n_errors++; $display("FAIL rnd_last c%0d: got %b expected %b", c, oLast, (m_busy && m_idx == 3)); end
      n_checks++; if (oCount !== 5'(m_q.size())) begin n_errors++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, oCount, m_q.size()); end
      n_checks++; if (oDropCount !== 16'(m_drops)) begin n_errors++; $display("FAIL rnd_drops c%0d: got %0d expected %0d", c, oDropCount, m_drops); end
      n_checks++; if (oOverflow !== m_ovf) begin n_errors++; $display("FAIL rnd_overflow c%0d: got %b expected %b", c, oOverflow, m_ovf); end
    end
    reset_n = 1'b1; iCapture = 1'b0; iClearOverflow = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; iCapture = 1'b0; iPC = '0; iInstruction = '0; iAluResult = '0;
    iRegWrite = 1'b0; iMemWrite = 1'b0; iMemRead = 1'b0; iClearOverflow = 1'b0; iReady = 1'b0;
    test_reset();
    test_single_record();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_clear_overflow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
